serial_add_acc: RTL and testbench
=================================

SERIAL_ADD_ACC -- requirements
Module: serial_add_acc

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured at accepted start.
REQ-006 b  input  WIDTH  operand B, captured at accepted start (ignored when accumulate=1).
REQ-007 sub  input  1  0 = A+B, 1 = A-B; captured at accepted start.
REQ-008 accumulate  input  1  1 = use current sum register as operand B; captured at accepted start.
REQ-009 busy  output  1  high while the operation is in progress (RUN state).
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sum  output  WIDTH  registered result of the last completed operation.
REQ-012 cout  output  1  carry out of MSB for last result (for sub: 1 = no borrow).
REQ-013 ovf  output  1  two's-complement signed overflow for last result.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: start=1 at an edge SHALL latch a, b (or sum if accumulate=1), sub, accumulate into internal shift registers, set the bit counter to 0, preset the carry flop to sub, and enter RUN.
REQ-016 IDLE with start=0 SHALL remain in IDLE; outputs hold.
REQ-017 RUN: each edge SHALL process exactly one bit pair, LSB first, using a 1-bit full adder with B inverted when sub=1; sum bit shifted into the result shift register, carry flop updated.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1, sum, cout and ovf SHALL be updated with the complete result and the FSM SHALL enter DONE.
REQ-019 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-020 Result arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-021 DONE: done SHALL be 1 for exactly this one cycle; next edge returns to IDLE unconditionally.
REQ-022 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH; next start accepted at edge k+WIDTH+2 at the earliest.
REQ-023 busy SHALL be 1 only in RUN; done only in DONE; busy and done never high together.
REQ-024 start asserted in RUN or DONE SHALL be ignored, with no queuing and no effect on the running operation.
REQ-025 Changes on a, b, sub, accumulate during RUN SHALL NOT affect the result.
REQ-026 sum, cout, ovf SHALL hold their values from completion until the next completion; they are not cleared at start.
REQ-027 accumulate=1 SHALL use the sum value present at the accepting edge (the previous result).

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock, force FSM=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter, carry and shift registers=0.
REQ-029 Reset asserted during RUN SHALL abort the operation; no done pulse and no result update occur.
REQ-030 After rst_n deasserts, the first edge SHALL behave as IDLE.

Verification (WIDTH=8)
REQ-031 a=0x0F, b=0x01, sub=0, start at edge k -> busy high 8 cycles, done in cycle after edge k+8, sum=0x10, cout=0, ovf=0.
REQ-032 a=0xFF+b=0x01 -> sum=0x00, cout=1, ovf=0; a=0x7F+b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-033 a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-034 After sum=0x10, start with accumulate=1, a=0x22, b=0xAA -> sum=0x32 (b ignored); repeat -> sum=0x54.
REQ-035 start pulsed during RUN with different operands and a/b toggled mid-run -> exactly one done, result of the originally captured operands.
REQ-036 rst_n low at RUN cycle 4 -> busy=0, sum=0 immediately, no done; a new start after release yields a correct result.

Source files
------------

// File: rtl/serial_add_acc.sv
// serial_add_acc: bit-serial adder/subtractor with optional accumulate.
// Each operation takes WIDTH cycles in RUN. One result bit is produced per
// cycle, LSB first, by a single full adder and a carry flop.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - request a new operation (sampled only in IDLE)
//   a, b       - operands, captured at an accepted start
//   sub        - 0: a+b, 1: a-b (captured at start)
//   accumulate - 1: use the current sum as operand B (captured at start)
//   busy       - high while in RUN
//   done       - one-cycle completion pulse (DONE state)
//   sum        - result of the last completed operation
//   cout       - carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf        - two's-complement signed overflow of the last result
module serial_add_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             accumulate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_q;

  // Full adder on the current LSB pair; B is inverted for subtraction and
  // the carry flop is preset to sub, giving a + ~b + 1.
  logic bit_b;
  logic bit_s;
  logic bit_c;

  always_comb begin
    bit_b = b_sr[0] ^ sub_q;
    bit_s = a_sr[0] ^ bit_b ^ carry;
    bit_c = (a_sr[0] & bit_b) | (a_sr[0] & carry) | (bit_b & carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= accumulate ? sum : b;
            sub_q  <= sub;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= sub;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {bit_s, res_sr[WIDTH-1:1]};
          carry  <= bit_c;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // On the MSB step the carry flop still holds the carry into
            // the MSB, so overflow is that XOR the carry out.
            sum  <= {bit_s, res_sr[WIDTH-1:1]};
            cout <= bit_c;
            ovf  <= bit_c ^ carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_acc.sv
// Testbench for serial_add_acc (WIDTH=8): directed operations, expected
// results queued when an operation is launched and compared at done.
module tb_serial_add_acc;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         accumulate;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  res_t         exp_q[$];
  logic [W-1:0] model_sum;

  serial_add_acc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .accumulate (accumulate),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic, independent of the serial structure.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    res_t         r;
    logic [W-1:0] yo;
    logic [W:0]   full;
    yo     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yo} + {{W{1'b0}}, s};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == yo[W-1]) && (r.sum[W-1] != x[W-1]);
    return r;
  endfunction

  // Called at a negedge while the DUT is IDLE; returns at the negedge of the
  // IDLE cycle following DONE, so a follow-on call starts at the earliest edge.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic iacc, input logic disturb);
    res_t         e;
    res_t         got;
    logic [W-1:0] prev;
    int           n;
    prev = model_sum;
    e = model(ia, iacc ? model_sum : ib, isub);
    model_sum = e.sum;
    exp_q.push_back(e);
    start = 1'b1; a = ia; b = ib; sub = isub; accumulate = iacc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      check("busy_in_run", {31'b0, busy}, 32'd1);
      check("sum_held_in_run", {24'b0, sum}, {24'b0, prev});
      if (disturb && n == 2) begin
        start = 1'b1; a = ~ia; b = ia ^ 8'h5A; sub = ~isub; accumulate = ~iacc;
      end
      if (disturb && n == 4) begin
        start = 1'b0; a = 8'hC3; b = 8'h3C;
      end
      n++;
      @(negedge clk);
    end
    check("latency", n, W);
    check("busy_in_done", {31'b0, busy}, 32'd0);
    got = '{sum: sum, cout: cout, ovf: ovf};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sum", {24'b0, got.sum}, {24'b0, e.sum});
      check("cout", {31'b0, got.cout}, {31'b0, e.cout});
      check("ovf", {31'b0, got.ovf}, {31'b0, e.ovf});
    end else begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end
    if (disturb) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", {31'b0, done}, 32'd0);
    if (disturb) begin
      // start during RUN and DONE must have been dropped entirely.
      for (int i = 0; i < 12; i++) begin
        if (done !== 1'b0 || busy !== 1'b0) check("no_extra_op", {30'b0, busy, done}, 32'd0);
        @(negedge clk);
      end
      check("idle_after_ignored_start", {30'b0, busy, done}, 32'd0);
      check("sum_after_ignored_start", {24'b0, sum}, {24'b0, model_sum});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0; accumulate = 1'b0;
    model_sum = '0;
    #2;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_sum", {24'b0, sum}, 32'd0);
    check("reset_flags", {30'b0, cout, ovf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);   // 0x10
    run_op(8'h22, 8'hAA, 1'b0, 1'b1, 1'b0);   // 0x32, b ignored
    run_op(8'h22, 8'hAA, 1'b0, 1'b1, 1'b0);   // 0x54
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);   // 0x00 c=1
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);   // 0x80 v=1
    run_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b0);   // 0xFE
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);   // 0x7F c=1 v=1
    run_op(8'h3C, 8'h15, 1'b0, 1'b0, 1'b1);   // disturbed run
    run_op(8'h10, 8'h00, 1'b1, 1'b1, 1'b0);   // 0x10 - sum

    // Hold: outputs keep the last result while idle.
    repeat (3) @(negedge clk);
    check("hold_sum", {24'b0, sum}, {24'b0, model_sum});

    // Abort in the middle of RUN with an asynchronous reset.
    start = 1'b1; a = 8'h44; b = 8'h11; sub = 1'b0; accumulate = 1'b0;
    exp_q.push_back(model(8'h44, 8'h11, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_sum", {24'b0, sum}, 32'd0);
    check("abort_flags", {29'b0, done, cout, ovf}, 32'd0);
    exp_q.delete();
    model_sum = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0) check("no_done_after_abort", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    check("idle_after_abort", {30'b0, busy, done}, 32'd0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);   // 0x46
    run_op(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);   // accumulate after reset

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
